// File: rtl/pixel_io_pkg.sv
// Shared definitions for the output-pixel path of the segmented data memory.
// Holds the streamer FSM state encoding, the memory-map constants of the
// pixel regions and a helper that sizes counters.
package pixel_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    READ,
    SEND,
    DONE
  } state_e;

  // Memory map of the data memory as seen by the pixel I/O blocks.
  localparam int IN_BASE       = 0;
  localparam int OUT_BASE      = 24;
  localparam int OUT_WORDS     = 10000;
  localparam int START_IO_ADDR = 180302;

  localparam int PIXEL_W = 24;
  localparam int BYTE_W  = 8;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_out_streamer_if.sv
// Bus bundle of the pixel output streamer.
//   bus_req / bus_gnt     : request/grant pair towards the memory-port arbiter
//   mem_addr / mem_rdata  : shared data port of the memory (rd2 is combinational)
//   tx_data / tx_valid /
//   tx_ready              : byte stream towards the UART/IO transmitter
// Modport master is the streamer, slave is the environment (memory, arbiter,
// transmitter).
interface pixel_out_streamer_if
  import pixel_io_pkg::*;
#(
  parameter int WIDTH = PIXEL_W
);

  logic              bus_req;
  logic              bus_gnt;
  logic [WIDTH-1:0]  mem_addr;
  logic [WIDTH-1:0]  mem_rdata;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output bus_req, mem_addr, tx_data, tx_valid,
    input  bus_gnt, mem_rdata, tx_ready
  );

  modport slave (
    input  bus_req, mem_addr, tx_data, tx_valid,
    output bus_gnt, mem_rdata, tx_ready
  );

endinterface

// File: rtl/pixel_out_streamer_byte_serializer.sv
// Byte serializer: loads one BYTES-byte word and presents it MSB first on a
// valid/ready byte stream.
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture word and start presenting its first byte
//   word         : word to serialize
//   tx_data      : current byte, held stable until accepted
//   tx_valid     : tx_data is valid
//   tx_ready     : downstream accepts the byte this cycle
//   last_accept  : the final byte of the word is being accepted this cycle
module byte_serializer
  import pixel_io_pkg::*;
#(
  parameter int BYTES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BYTES*BYTE_W-1:0] word,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    last_accept
);

  localparam int W     = BYTES * BYTE_W;
  localparam int IDX_W = cnt_width(BYTES);

  logic [W-1:0]     shreg;
  logic [W-1:0]     shreg_next;
  logic [IDX_W-1:0] idx;
  logic             accept;

  // The byte currently on tx_data always sits in the top of shreg, so the
  // next byte is simply the top of the left-shifted register.
  assign shreg_next  = shreg << BYTE_W;
  assign accept      = tx_valid && tx_ready;
  assign last_accept = accept && (idx == IDX_W'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= word;
    end else if (accept) begin
      shreg <= shreg_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      idx      <= '0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= word[W-1 -: BYTE_W];
      idx      <= '0;
    end else if (accept) begin
      if (idx == IDX_W'(BYTES - 1)) begin
        tx_valid <= 1'b0;
        idx      <= '0;
      end else begin
        idx     <= idx + 1'b1;
        tx_data <= shreg_next[W-1 -: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/pixel_out_streamer.sv
// Pixel output streamer: after a frame is finished, sweeps the output-pixel
// region of the data memory word by word through the shared data port and
// streams every pixel as BYTES_PER_WORD bytes, MSB first, to the transmitter.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse that begins a frame dump (ignored while busy)
//   busy      : frame dump in progress
//   done      : one-cycle pulse after the last byte has been accepted
//   bus       : memory port, arbiter handshake and byte stream (master side)
module pixel_out_streamer
  import pixel_io_pkg::*;
#(
  parameter int WIDTH          = PIXEL_W,
  parameter int BASE_ADDR      = OUT_BASE,
  parameter int NUM_WORDS      = OUT_WORDS,
  parameter int BYTES_PER_WORD = PIXEL_W / BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  pixel_out_streamer_if.master   bus
);

  localparam int CNT_W = cnt_width(NUM_WORDS);
  localparam int PIX_W = BYTES_PER_WORD * BYTE_W;

  state_e             state;
  logic [CNT_W-1:0]   word_cnt;
  logic [WIDTH-1:0]   mem_addr_q;
  logic               bus_req_q;
  logic               busy_q;
  logic               done_q;
  logic               load;
  logic               last_accept;
  logic [BYTE_W-1:0]  tx_data_w;
  logic               tx_valid_w;

  // The memory answers combinationally, so the pixel is captured in the very
  // cycle READ still holds the grant; without grant nothing is loaded.
  assign load = (state == READ) && bus.bus_gnt;

  byte_serializer #(
    .BYTES (BYTES_PER_WORD)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .word        (bus.mem_rdata[PIX_W-1:0]),
    .tx_data     (tx_data_w),
    .tx_valid    (tx_valid_w),
    .tx_ready    (bus.tx_ready),
    .last_accept (last_accept)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      mem_addr_q <= '0;
      bus_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            word_cnt   <= '0;
            mem_addr_q <= WIDTH'(BASE_ADDR);
            busy_q     <= 1'b1;
            bus_req_q  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_gnt) begin
            state <= READ;
          end
        end
        READ: begin
          // Grant lost on the read cycle: keep requesting the same address.
          if (bus.bus_gnt) begin
            bus_req_q <= 1'b0;
            state     <= SEND;
          end else begin
            state <= REQ;
          end
        end
        SEND: begin
          // The port is released while bytes drain; it is re-requested only
          // once the whole pixel has been handed to the transmitter.
          if (last_accept) begin
            if (word_cnt == CNT_W'(NUM_WORDS - 1)) begin
              state <= DONE;
            end else begin
              word_cnt   <= word_cnt + 1'b1;
              mem_addr_q <= mem_addr_q + 1'b1;
              bus_req_q  <= 1'b1;
              state      <= REQ;
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bus_req  = bus_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.tx_data  = tx_data_w;
  assign bus.tx_valid = tx_valid_w;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
